// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler
//   Shares one measurement engine between NUM_CH sensor channels. A free-running
//   tick (every CLK_FREQ/POLL_HZ cycles) starts one measurement on the next enabled
//   channel in round-robin order. Handles the start/done handshake, timeout and tick
//   overrun. Publishes tagged samples downstream.
//
//   Optional feature: define WARN_THRESH_EN to compare each sample against thresh
//   and update warn[sample_ch]. Without it, warn is tied to 0 and thresh is ignored.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   ch_enable       per-channel poll enable, sampled when a slot selects a channel
//   meas_start      1-cycle start pulse to the engine, channel on meas_ch
//   meas_ch         channel under measurement, stable from START through WAIT
//   meas_done       1-cycle engine completion pulse, meas_data valid with it
//   meas_data       engine result
//   sample_valid    1-cycle pulse, sample_ch/sample_data updated
//   sample_ch       channel of the last sample (held)
//   sample_data     value of the last sample (held)
//   timeout_err     1-cycle pulse, measurement aborted by timeout
//   overrun         sticky, a tick arrived while a slot was still busy
//   thresh          warning threshold (WARN_THRESH_EN only)
//   warn            per-channel warning flags
module sensor_poll_scheduler #(
    parameter int CLK_FREQ    = 40_000_000,
    parameter int POLL_HZ     = 1_000,
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 4_000,
    localparam int TICK_DIV   = CLK_FREQ / POLL_HZ,
    localparam int CW         = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              meas_start,
    output logic [CW-1:0]     meas_ch,
    input  logic              meas_done,
    input  logic [DATA_W-1:0] meas_data,
    output logic              sample_valid,
    output logic [CW-1:0]     sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              timeout_err,
    output logic              overrun,
    input  logic [DATA_W-1:0] thresh,
    output logic [NUM_CH-1:0] warn
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        STORE
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [WW-1:0]     wait_cnt;
    logic [CW-1:0]     last_ch;
    logic [CW-1:0]     sel_ch;
    logic              sel_found;
    logic [DATA_W-1:0] data_q;

    // Free-running slot timer; runs regardless of FSM state.
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Round-robin search starting just after the last served channel.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = last_ch;
        for (int i = 1; i <= NUM_CH; i++) begin
            int idx;
            idx = (int'(last_ch) + i) % NUM_CH;
            if (!sel_found && ch_enable[idx]) begin
                sel_found = 1'b1;
                sel_ch    = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        meas_start  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE:   if (tick) state_nxt = SELECT;
            SELECT: state_nxt = sel_found ? START : IDLE;
            START: begin
                meas_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A completion in the final counter cycle still counts.
                if (meas_done) begin
                    state_nxt = STORE;
                end else if (wait_cnt == WW'(TIMEOUT_CYC)) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Channel bookkeeping. The pointer advances at selection time, so a channel
    // that times out is not retried ahead of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ch <= CW'(NUM_CH - 1);
            meas_ch <= '0;
        end else if (state == SELECT && sel_found) begin
            last_ch <= sel_ch;
            meas_ch <= sel_ch;
        end
    end

    // Wait counter reads 0 in the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == WAIT && meas_done) begin
                data_q <= meas_data;
            end
            if (state == STORE) begin
                sample_valid <= 1'b1;
                sample_ch    <= meas_ch;
                sample_data  <= data_q;
            end
            // Dropped tick: the in-flight slot carries on untouched.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef WARN_THRESH_EN
    // Written together with sample_valid so both are visible in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn <= '0;
        end else if (state == STORE) begin
            warn[meas_ch] <= (data_q >= thresh);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign warn          = '0;
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Randomized scoreboard bench for sensor_poll_scheduler.
// The reference model works per slot: at every tick it decides, from the
// enable mask and the round-robin pointer, which channel is served. It also draws
// the engine's response delay and queues the cycles at which meas_start, sample_valid
// or timeout_err must appear. A negedge monitor pops and compares.
// TIMEOUT_CYC is 48 here so that a 45-cycle engine answer is legal and overruns a tick.
module tb_sensor_poll_scheduler;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int TO     = 48;
    localparam int TD     = 40;
    localparam int INF    = 1 << 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] ch_enable = '1;
    logic              meas_start;
    logic [1:0]        meas_ch;
    logic              meas_done = 1'b0;
    logic [DATA_W-1:0] meas_data = '0;
    logic              sample_valid;
    logic [1:0]        sample_ch;
    logic [DATA_W-1:0] sample_data;
    logic              timeout_err;
    logic              overrun;
    logic [DATA_W-1:0] thresh = 12'h800;
    logic [NUM_CH-1:0] warn;

    sensor_poll_scheduler #(
        .CLK_FREQ(40_000_000), .POLL_HZ(1_000_000), .NUM_CH(NUM_CH),
        .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .ch_enable(ch_enable),
        .meas_start(meas_start), .meas_ch(meas_ch),
        .meas_done(meas_done), .meas_data(meas_data),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .timeout_err(timeout_err), .overrun(overrun),
        .thresh(thresh), .warn(warn)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; cycle 0 is the one in which rst drops.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct { int c; int ch; } ev_t;
    typedef struct { int c; int ch; logic [DATA_W-1:0] data; logic [NUM_CH-1:0] w; } smp_t;
    typedef struct { int d; logic [DATA_W-1:0] data; } eng_t;

    ev_t  q_start[$];
    smp_t q_smp[$];
    int   q_to[$];
    eng_t q_eng[$];

    int total = 0;
    int bad   = 0;

    // Model state
    int                last_m;
    int                idle_at;
    int                ovr_at;
    int                last_start;
    int                mode;
    logic [NUM_CH-1:0] warn_m;

    // Engine state
    int                pend = 0;
    logic [DATA_W-1:0] pend_data;

    task automatic init_model();
        last_m  = NUM_CH - 1;
        idle_at = 0;
        ovr_at  = INF;
        warn_m  = '0;
        q_start.delete();
        q_smp.delete();
        q_to.delete();
        q_eng.delete();
    endtask

    // One slot decision at tick cycle c.
    task automatic model_tick(input int c);
        int                ch;
        int                d;
        int                r;
        logic [DATA_W-1:0] data;
        ch = -1;
        if (c < idle_at) begin
            if (ovr_at > c) ovr_at = c;
            return;
        end
        for (int i = 1; i <= NUM_CH; i++)
            if (ch < 0 && ch_enable[(last_m + i) % NUM_CH]) ch = (last_m + i) % NUM_CH;
        if (ch < 0) return;
        last_m     = ch;
        last_start = c + 2;
        q_start.push_back('{c + 2, ch});
        r    = int'($urandom_range(0, 9));
        data = DATA_W'($urandom_range(0, 4095));
        if (r == 0) data = 12'h7FF;
        if (r == 1) data = 12'h800;
        case (mode)
            0: begin d = 5; data = 12'h100 + DATA_W'(ch); end
            1: d = int'($urandom_range(1, 30));
            2: begin
                d = int'($urandom_range(1, TO + 1));
                if (r < 2) d = 0;              // never answers
                else if (r == 2) d = TO + 1;   // answers in the last allowed cycle
                else if (r == 3) d = 45;
            end
            default: d = 10;
        endcase
        if (d == 0) begin
            q_to.push_back(c + 2 + TO + 1);
            idle_at = c + 2 + TO + 2;
        end else begin
`ifdef WARN_THRESH_EN
            warn_m[ch] = (data >= thresh);
`endif
            q_smp.push_back('{c + 2 + d + 2, ch, data, warn_m});
            idle_at = c + 2 + d + 2;
        end
        q_eng.push_back('{d, data});
    endtask

    // Called once per cycle, 2 time units after the rising edge.
    task automatic step();
        logic [NUM_CH-1:0] tbl [5];
        eng_t e;
        tbl = '{4'hF, 4'h5, 4'h0, 4'hA, 4'h2};
        meas_done = 1'b0;
        meas_data = DATA_W'($urandom_range(0, 4095));
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                meas_done = 1'b1;
                meas_data = pend_data;
            end
        end
        if (meas_start && q_eng.size() > 0) begin
            e = q_eng.pop_front();
            if (e.d > 0) begin
                pend      = e.d;
                pend_data = e.data;
            end
        end
        if ((mode == 1 || mode == 2) && cyc % TD == 10)
            ch_enable = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom_range(0, 15))
                                                     : tbl[$urandom_range(0, 4)];
        if (cyc % TD == TD - 1) model_tick(cyc);
    endtask

    task automatic run(input int n, input int m);
        mode = m;
        repeat (n) begin
            @(posedge clk);
            #2;
            step();
        end
    endtask

    // Asserts rst for one cycle; checks the reset state; releases into cycle 0.
    task automatic drive_reset();
        rst       = 1'b1;
        meas_done = 1'b0;
        #1;
        total++;
        if ({meas_start, meas_ch, sample_valid, sample_ch, sample_data,
             timeout_err, overrun, warn} !== '0) begin
            bad++;
            $display("FAIL reset_state got start=%b ch=%0d sv=%b sch=%0d sdata=%h to=%b ovr=%b warn=%b want all 0",
                     meas_start, meas_ch, sample_valid, sample_ch, sample_data,
                     timeout_err, overrun, warn);
        end
        init_model();
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (overrun !== (cyc > ovr_at)) begin
                bad++;
                $display("FAIL overrun cyc=%0d got %b want %b", cyc, overrun, cyc > ovr_at);
            end
            if (q_start.size() > 0 && q_start[0].c < cyc) begin
                total++; bad++;
                $display("FAIL missing_start want cyc=%0d ch=%0d got none", q_start[0].c, q_start[0].ch);
                void'(q_start.pop_front());
            end
            if (q_smp.size() > 0 && q_smp[0].c < cyc) begin
                total++; bad++;
                $display("FAIL missing_sample want cyc=%0d ch=%0d got none", q_smp[0].c, q_smp[0].ch);
                void'(q_smp.pop_front());
            end
            if (q_to.size() > 0 && q_to[0] < cyc) begin
                total++; bad++;
                $display("FAIL missing_timeout want cyc=%0d got none", q_to[0]);
                void'(q_to.pop_front());
            end
            if (meas_start) begin
                total++;
                if (q_start.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_start cyc=%0d ch=%0d want none", cyc, meas_ch);
                end else begin
                    ev_t s;
                    s = q_start.pop_front();
                    if (s.c != cyc || int'(meas_ch) != s.ch) begin
                        bad++;
                        $display("FAIL start got cyc=%0d ch=%0d want cyc=%0d ch=%0d", cyc, meas_ch, s.c, s.ch);
                    end
                end
            end
            if (sample_valid) begin
                total++;
                if (q_smp.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_sample cyc=%0d ch=%0d data=%h want none", cyc, sample_ch, sample_data);
                end else begin
                    smp_t s;
                    s = q_smp.pop_front();
                    if (s.c != cyc || int'(sample_ch) != s.ch || sample_data !== s.data || warn !== s.w) begin
                        bad++;
                        $display("FAIL sample got cyc=%0d ch=%0d data=%h warn=%b want cyc=%0d ch=%0d data=%h warn=%b",
                                 cyc, sample_ch, sample_data, warn, s.c, s.ch, s.data, s.w);
                    end
                end
            end
            if (timeout_err) begin
                total++;
                if (q_to.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_timeout cyc=%0d want none", cyc);
                end else begin
                    int t;
                    t = q_to.pop_front();
                    if (t != cyc) begin
                        bad++;
                        $display("FAIL timeout got cyc=%0d want cyc=%0d", cyc, t);
                    end
                end
            end
        end
    end

    initial begin
        bit hit;
        mode       = 0;
        last_start = -100;
        init_model();
        @(posedge clk);
        #2;
        drive_reset();

        // All channels, fixed 5-cycle engine answering 0x100+ch.
        ch_enable = 4'hF;
        run(400, 0);
        // Random enable masks (including none), short answers.
        run(1600, 1);

        // Reset in the middle of a measurement; the engine still answers afterwards.
        mode       = 3;
        ch_enable  = 4'hF;
        last_start = -100;
        hit        = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(posedge clk);
            #2;
            if (last_start >= 0 && cyc == last_start + 3) hit = 1'b1;
            else step();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL mid_reset_window got no start within 400 cycles want one");
        end else begin
            drive_reset();
        end
        run(300, 1);

        // Long answers, last-cycle answers and no-answer timeouts (overruns).
        run(2000, 2);

        // Quiet tail: nothing enabled, so no further starts.
        ch_enable = 4'h0;
        mode      = 1;
        repeat (200) begin
            @(posedge clk);
            #2;
            ch_enable = 4'h0;
            step();
        end

        total++;
        if (q_start.size() + q_smp.size() + q_to.size() != 0) begin
            bad++;
            $display("FAIL drain got pending start=%0d sample=%0d timeout=%0d want 0",
                     q_start.size(), q_smp.size(), q_to.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
